local_bias_ctrl: RTL and testbench

Digital power-up sequencer and analog test bus controller for the `local_bias` block. It drives `pdb` and `atb_ena` of `local_bias` from the digital domain. It qualifies supply-good flags, enforces a bias settle time before declaring bias ready, applies test bus selections through a request/acknowledge handshake, and forces a safe power-down on supply loss.

---
 rtl/local_bias_ctrl.sv | 175 +++++++++++++++++
 tb/tb_local_bias_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/local_bias_ctrl.sv
// Power-up sequencer and analog test bus controller for local_bias (pdb / atb_ena).
// Define LOCAL_BIAS_CTRL_SYNC_EN to pass the supply-good flags through 2-flop synchronizers.
module local_bias_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned ATB_SETTLE    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       vdd1p8_ok,
  input  logic       vdd0p8_ok,
  input  logic [1:0] atb_sel,
  input  logic       atb_req,
  input  logic       fault_clr,
  output logic       pdb,
  output logic [1:0] atb_ena,
  output logic       bias_ready,
  output logic       atb_busy,
  output logic       atb_ack,
  output logic       fault
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES) + 1;
  localparam int unsigned AW = $clog2(ATB_SETTLE) + 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [AW-1:0] ATB_LOAD    = AW'(ATB_SETTLE - 1);

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_WAIT_SUP = 3'd1,
    S_SETTLE   = 3'd2,
    S_READY    = 3'd3,
    S_FAULT    = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [SW-1:0] r_set_cnt;
  logic [SW-1:0] w_set_cnt_nxt;
  logic [AW-1:0] r_atb_cnt;
  logic [AW-1:0] w_atb_cnt_nxt;
  logic [1:0]    r_atb_ena;
  logic [1:0]    w_atb_ena_nxt;
  logic          r_atb_busy;
  logic          w_atb_busy_nxt;
  logic          r_atb_ack;
  logic          w_atb_ack_nxt;
  logic          r_pdb;
  logic          r_bias_ready;
  logic          r_fault;
  logic          w_sup_ok;

`ifdef LOCAL_BIAS_CTRL_SYNC_EN
  logic [1:0] r_sync_1p8;
  logic [1:0] r_sync_0p8;

  // Two-stage synchronizers for the asynchronous comparator flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_1p8 <= 2'b00;
      r_sync_0p8 <= 2'b00;
    end else begin
      r_sync_1p8 <= {r_sync_1p8[0], vdd1p8_ok};
      r_sync_0p8 <= {r_sync_0p8[0], vdd0p8_ok};
    end
  end

  assign w_sup_ok = r_sync_1p8[1] & r_sync_0p8[1];
`else
  assign w_sup_ok = vdd1p8_ok & vdd0p8_ok;
`endif

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_OFF;
      r_set_cnt    <= '0;
      r_atb_cnt    <= '0;
      r_atb_ena    <= 2'b00;
      r_atb_busy   <= 1'b0;
      r_atb_ack    <= 1'b0;
      r_pdb        <= 1'b0;
      r_bias_ready <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_set_cnt    <= w_set_cnt_nxt;
      r_atb_cnt    <= w_atb_cnt_nxt;
      r_atb_ena    <= w_atb_ena_nxt;
      r_atb_busy   <= w_atb_busy_nxt;
      r_atb_ack    <= w_atb_ack_nxt;
      r_pdb        <= (w_state_nxt == S_SETTLE) || (w_state_nxt == S_READY);
      r_bias_ready <= (w_state_nxt == S_READY);
      r_fault      <= (w_state_nxt == S_FAULT);
    end
  end

  // Next-state, counter and ATB handshake logic; supply loss outranks enable drop
  always_comb begin
    w_state_nxt    = r_state;
    w_set_cnt_nxt  = '0;
    w_atb_cnt_nxt  = '0;
    w_atb_ena_nxt  = r_atb_ena;
    w_atb_busy_nxt = 1'b0;
    w_atb_ack_nxt  = 1'b0;

    case (r_state)
      S_OFF: begin
        if (enable) w_state_nxt = S_WAIT_SUP;
      end
      S_WAIT_SUP: begin
        if (!w_sup_ok) begin
          w_state_nxt = S_FAULT;
        end else if (!enable) begin
          w_state_nxt = S_OFF;
        end else begin
          w_state_nxt   = S_SETTLE;
          w_set_cnt_nxt = SETTLE_LOAD;
        end
      end
      S_SETTLE: begin
        if (!w_sup_ok) begin
          w_state_nxt = S_FAULT;
        end else if (!enable) begin
          w_state_nxt = S_OFF;
        end else if (r_set_cnt == '0) begin
          w_state_nxt = S_READY;
        end else begin
          w_set_cnt_nxt = r_set_cnt - SW'(1);
        end
      end
      S_READY: begin
        if (!w_sup_ok) begin
          w_state_nxt = S_FAULT;
        end else if (!enable) begin
          w_state_nxt = S_OFF;
        end else if (r_atb_busy) begin
          // Requests arriving while busy are dropped
          if (r_atb_cnt == '0) begin
            w_atb_ack_nxt = 1'b1;
          end else begin
            w_atb_busy_nxt = 1'b1;
            w_atb_cnt_nxt  = r_atb_cnt - AW'(1);
          end
        end else if (atb_req) begin
          w_atb_ena_nxt  = atb_sel;
          w_atb_busy_nxt = 1'b1;
          w_atb_cnt_nxt  = ATB_LOAD;
        end
      end
      S_FAULT: begin
        if (fault_clr) w_state_nxt = S_OFF;
      end
      default: begin
        w_state_nxt = S_OFF;
      end
    endcase

    // Test bus selection only lives while READY
    if (w_state_nxt != S_READY) begin
      w_atb_ena_nxt  = 2'b00;
      w_atb_busy_nxt = 1'b0;
      w_atb_ack_nxt  = 1'b0;
      w_atb_cnt_nxt  = '0;
    end
  end

  assign pdb        = r_pdb;
  assign atb_ena    = r_atb_ena;
  assign bias_ready = r_bias_ready;
  assign atb_busy   = r_atb_busy;
  assign atb_ack    = r_atb_ack;
  assign fault      = r_fault;

endmodule

// File: tb/tb_local_bias_ctrl.sv
// Scoreboard bench for local_bias_ctrl: a timestamp-based reference model predicts outputs per edge.
`timescale 1ns/1ns
module tb_local_bias_ctrl;

  localparam int unsigned SETTLE = 4;
  localparam int unsigned ATB    = 2;

  localparam int MD_OFF  = 0;
  localparam int MD_WAIT = 1;
  localparam int MD_SET  = 2;
  localparam int MD_RDY  = 3;
  localparam int MD_FLT  = 4;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       vdd1p8_ok;
  logic       vdd0p8_ok;
  logic [1:0] atb_sel;
  logic       atb_req;
  logic       fault_clr;
  logic       pdb;
  logic [1:0] atb_ena;
  logic       bias_ready;
  logic       atb_busy;
  logic       atb_ack;
  logic       fault;

  local_bias_ctrl #(
    .SETTLE_CYCLES(SETTLE),
    .ATB_SETTLE   (ATB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .vdd1p8_ok (vdd1p8_ok),
    .vdd0p8_ok (vdd0p8_ok),
    .atb_sel   (atb_sel),
    .atb_req   (atb_req),
    .fault_clr (fault_clr),
    .pdb       (pdb),
    .atb_ena   (atb_ena),
    .bias_ready(bias_ready),
    .atb_busy  (atb_busy),
    .atb_ack   (atb_ack),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    time        t;
    logic [6:0] v;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: mode plus absolute edge timestamps for settle and ack deadlines
  int         m_mode;
  int         m_edge;
  int         m_pdb_edge;
  int         m_ack_edge;
  logic [1:0] m_ena;
  logic       m_h1;
  logic       m_h2;

  function automatic logic [6:0] dut_out();
    return {pdb, atb_ena, bias_ready, atb_busy, atb_ack, fault};
  endfunction

  function automatic void check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: pdb,ena,rdy,busy,ack,flt got %b required %b", name, act, exp);
    end
  endfunction

  task automatic model_reset();
    m_mode     = MD_OFF;
    m_edge     = 0;
    m_pdb_edge = 0;
    m_ack_edge = -1;
    m_ena      = 2'b00;
    m_h1       = 1'b0;
    m_h2       = 1'b0;
  endtask

  function automatic logic [6:0] model_step(input logic en, input logic raw_ok, input logic [1:0] sel,
                                            input logic req, input logic clr);
    logic sup;
    logic ack;
    m_edge++;
`ifdef LOCAL_BIAS_CTRL_SYNC_EN
    sup  = m_h2;
    m_h2 = m_h1;
    m_h1 = raw_ok;
`else
    sup = raw_ok;
`endif
    ack = 1'b0;
    case (m_mode)
      MD_OFF: if (en) m_mode = MD_WAIT;
      MD_WAIT: begin
        if (!sup) m_mode = MD_FLT;
        else if (!en) m_mode = MD_OFF;
        else begin
          m_mode     = MD_SET;
          m_pdb_edge = m_edge;
        end
      end
      MD_SET: begin
        if (!sup) m_mode = MD_FLT;
        else if (!en) m_mode = MD_OFF;
        else if (m_edge - m_pdb_edge == int'(SETTLE)) m_mode = MD_RDY;
      end
      MD_RDY: begin
        if (!sup) m_mode = MD_FLT;
        else if (!en) m_mode = MD_OFF;
        else if (m_ack_edge >= 0) begin
          if (m_edge == m_ack_edge) begin
            ack        = 1'b1;
            m_ack_edge = -1;
          end
        end else if (req) begin
          m_ena      = sel;
          m_ack_edge = m_edge + int'(ATB);
        end
      end
      default: if (clr) m_mode = MD_OFF;
    endcase
    if (m_mode != MD_RDY) begin
      m_ena      = 2'b00;
      m_ack_edge = -1;
    end
    return {(m_mode == MD_SET) || (m_mode == MD_RDY), m_ena, m_mode == MD_RDY,
            m_ack_edge >= 0, ack, m_mode == MD_FLT};
  endfunction

  // Drive one cycle of inputs after a rising edge and queue what the next edge must produce
  task automatic step(input logic en, input logic v18, input logic v08, input logic [1:0] sel,
                      input logic req, input logic clr);
    exp_t e;
    @(posedge clk);
    #2;
    enable    = en;
    vdd1p8_ok = v18;
    vdd0p8_ok = v08;
    atb_sel   = sel;
    atb_req   = req;
    fault_clr = clr;
    e.t = $time + 64'd8;
    e.v = model_step(en, v18 & v08, sel, req, clr);
    sb_q.push_back(e);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected entries left, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic async_reset_check();
    drain();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst", dut_out(), 7'b0);
    enable    = 1'b0;
    vdd1p8_ok = 1'b0;
    vdd0p8_ok = 1'b0;
    atb_req   = 1'b0;
    fault_clr = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: compare the entry stamped for this edge on the following falling edge
  initial begin
    time  tnow;
    exp_t e;
    forever begin
      @(posedge clk);
      tnow = $time;
      @(negedge clk);
      if (sb_q.size() > 0 && sb_q[0].t == tnow) begin
        e = sb_q.pop_front();
        check($sformatf("out@%0t", tnow), dut_out(), e.v);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    vdd1p8_ok = 1'b0;
    vdd0p8_ok = 1'b0;
    atb_sel   = 2'b00;
    atb_req   = 1'b0;
    fault_clr = 1'b0;
    model_reset();
    #1;
    check("reset", dut_out(), 7'b0);
    #11;
    rst = 1'b0;

    // Power-up to READY
    repeat (7) step(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);

    // ATB sweep with a second request during busy
    for (int s = 1; s < 4; s++) begin
      step(1'b1, 1'b1, 1'b1, 2'(s), 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 2'(s ^ 3), 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    end

    // Supply loss with atb_ena=11, enable ignored until fault_clr
    step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);

    // Enable drop two cycles into SETTLE
    repeat (4) step(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);

    // Power-up, select a bus, then async reset and fresh power-up
    repeat (7) step(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    async_reset_check();
    repeat (7) step(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 19) != 0, $urandom_range(0, 49) != 0, $urandom_range(0, 49) != 0,
           2'($urandom_range(0, 3)), $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
    end

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
